// File: rtl/dct_frame_loader.sv
// ---------------------------------------------------------------------------
// dct_frame_loader
//
// Collects a stream of 16 N-bit two's-complement samples into a fill bank,
// then copies the whole frame in one cycle into a hold bank that drives the
// sixteen parallel inputs of a bit-serial DCT. After the copy it pulses init,
// waits CALC_CYCLES cycles for the DCT to finish and pulses frame_done.
// While the held frame is under computation the fill bank keeps accepting the
// next frame, so input streaming and computation overlap (double buffering).
//
// Handshake: a sample moves on a posedge where in_valid && in_ready. in_ready
// depends only on the fill bank being full, never on in_valid, so a producer
// may hold in_valid high while in_ready is low; in_data is then ignored.
//
// Ports
//   clk          clock, all state changes on posedge
//   clr          synchronous active-high reset, highest priority
//   in_data      sample, frame order in0 first, in15 last
//   in_valid     in_data valid this cycle
//   in_ready     loader can accept a sample this cycle
//   out0..out15  held frame, stable while busy
//   init         one-cycle start pulse to the DCT (START state)
//   busy         held frame under computation (state != IDLE)
//   frame_done   one-cycle pulse when the computation window ends
//   dbg_state    hold FSM state (IDLE=0, START=1, RUN=2, DONE=3)
//   dbg_wr_ptr   fill bank write slot
//   dbg_full     fill bank holds a complete frame waiting for the copy
// ---------------------------------------------------------------------------
module dct_frame_loader #(
    parameter int N           = 32,
    parameter int CALC_CYCLES = 36
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out0,
    output logic [N-1:0] out1,
    output logic [N-1:0] out2,
    output logic [N-1:0] out3,
    output logic [N-1:0] out4,
    output logic [N-1:0] out5,
    output logic [N-1:0] out6,
    output logic [N-1:0] out7,
    output logic [N-1:0] out8,
    output logic [N-1:0] out9,
    output logic [N-1:0] out10,
    output logic [N-1:0] out11,
    output logic [N-1:0] out12,
    output logic [N-1:0] out13,
    output logic [N-1:0] out14,
    output logic [N-1:0] out15,
    output logic         init,
    output logic         busy,
    output logic         frame_done,
    output logic [1:0]   dbg_state,
    output logic [3:0]   dbg_wr_ptr,
    output logic         dbg_full
);

    // Run counter must hold CALC_CYCLES-1 without wrapping; keep at least
    // 8 bits so the counter width does not shrink for small parameter values.
    localparam int CNT_NEED = $clog2(CALC_CYCLES + 1);
    localparam int CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0] fill [16];
    logic [N-1:0] hold [16];
    logic [3:0]   wr_ptr;
    logic         full;

    logic transfer;
    logic copy;

    // -----------------------------------------------------------------------
    // Fill side
    // -----------------------------------------------------------------------
    assign in_ready = !full;
    assign transfer = in_valid && in_ready;

    // The copy happens only on the edge leaving IDLE. A frame completed while
    // busy therefore waits in the fill bank, and in_ready stays low until then.
    assign copy = (state == S_IDLE) && full;

    // transfer needs !full and copy needs full, so they never coincide.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= 4'd0;
            full   <= 1'b0;
        end else if (transfer) begin
            wr_ptr <= wr_ptr + 4'd1;   // slot 15 wraps naturally to 0
            if (wr_ptr == 4'd15) begin
                full <= 1'b1;
            end
        end else if (copy) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                fill[i] <= '0;
            end
        end else if (transfer) begin
            fill[wr_ptr] <= in_data;
        end
    end

    // -----------------------------------------------------------------------
    // Hold bank: changes only on the copy edge or on reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                hold[i] <= '0;
            end
        end else if (copy) begin
            for (int i = 0; i < 16; i++) begin
                hold[i] <= fill[i];
            end
        end
    end

    assign out0  = hold[0];
    assign out1  = hold[1];
    assign out2  = hold[2];
    assign out3  = hold[3];
    assign out4  = hold[4];
    assign out5  = hold[5];
    assign out6  = hold[6];
    assign out7  = hold[7];
    assign out8  = hold[8];
    assign out9  = hold[9];
    assign out10 = hold[10];
    assign out11 = hold[11];
    assign out12 = hold[12];
    assign out13 = hold[13];
    assign out14 = hold[14];
    assign out15 = hold[15];

    // -----------------------------------------------------------------------
    // Hold FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        init       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (full) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                init       = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // RUN lasts CALC_CYCLES cycles: cnt runs 0..CALC_CYCLES-1.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (state == S_START) begin
            cnt <= '0;
        end else if (state == S_RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;
    assign dbg_wr_ptr = wr_ptr;
    assign dbg_full   = full;

endmodule

// File: tb/tb_dct_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_dct_frame_loader
//
// Directed bench for dct_frame_loader at default parameters. Stimulus is
// driven 1 time unit after each posedge; a negedge monitor checks every copied
// frame against the expected sample queue, the init-to-frame_done latency and
// the hold-bank stability while busy.
// ---------------------------------------------------------------------------
module tb_dct_frame_loader;

  localparam int N    = 32;
  localparam int CALC = 36;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] o [16];
  logic         init;
  logic         busy;
  logic         frame_done;
  logic [1:0]   dbg_state;
  logic [3:0]   dbg_wr_ptr;
  logic         dbg_full;

  always #5 clk = ~clk;

  dct_frame_loader #(.N(N), .CALC_CYCLES(CALC)) dut (
    .clk        (clk),
    .clr        (clr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0       (o[0]),
    .out1       (o[1]),
    .out2       (o[2]),
    .out3       (o[3]),
    .out4       (o[4]),
    .out5       (o[5]),
    .out6       (o[6]),
    .out7       (o[7]),
    .out8       (o[8]),
    .out9       (o[9]),
    .out10      (o[10]),
    .out11      (o[11]),
    .out12      (o[12]),
    .out13      (o[13]),
    .out14      (o[14]),
    .out15      (o[15]),
    .init       (init),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state),
    .dbg_wr_ptr (dbg_wr_ptr),
    .dbg_full   (dbg_full)
  );

  // ---------------- scoreboard state ----------------
  logic [N-1:0] exp_q[$];
  logic [N-1:0] snap [16];
  int           n_checks   = 0;
  int           n_errors   = 0;
  int           cyc        = 0;
  int           init_cyc   = 0;
  int           init_count = 0;
  int           done_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and return 1 unit after the edge that accepts it.
  task automatic send(input logic [N-1:0] v);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (in_ready !== 1'b1 && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) begin
      check("send_timeout", 32'(guard), 32'(0));
    end
    step();
    exp_q.push_back(v);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (frame_done !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check(tag, 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (!(busy === 1'b0 && in_ready === 1'b1 && dbg_full === 1'b0) && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) check(tag, 32'(0), 32'(1));
    step();
    check({tag, "_q_drained"}, 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    check("rdy_vs_full", 32'(in_ready), 32'(!dbg_full));
    if (init === 1'b1) begin
      init_count++;
      init_cyc = cyc;
      if (exp_q.size() < 16) begin
        check("init_without_full_frame", 32'(exp_q.size()), 32'(16));
      end else begin
        for (int k = 0; k < 16; k++) begin
          check($sformatf("frame_word%0d", k), o[k], exp_q.pop_front());
        end
      end
      for (int k = 0; k < 16; k++) snap[k] = o[k];
    end
    if (frame_done === 1'b1) begin
      done_count++;
      check("done_latency", 32'(cyc - init_cyc), 32'(CALC + 1));
      for (int k = 0; k < 16; k++) begin
        check($sformatf("hold_stable%0d", k), o[k], snap[k]);
      end
    end
  end

  // ---------------- main sequence ----------------
  int n;
  int init_before;
  int done_before;

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    clr = 1'b0;

    // Reset state
    check("rst_init", 32'(init), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(frame_done), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_wr_ptr", 32'(dbg_wr_ptr), 32'(0));
    for (int k = 0; k < 16; k++) check($sformatf("rst_out%0d", k), o[k], 32'(0));

    // ---- Single frame 1..16 ----
    for (int i = 1; i <= 16; i++) send(N'(i));
    check("sf_no_init_yet", 32'(init), 32'(0));
    check("sf_out0_old", o[0], 32'(0));
    check("sf_ready_low", 32'(in_ready), 32'(0));
    step();
    check("sf_init", 32'(init), 32'(1));
    check("sf_busy", 32'(busy), 32'(1));
    check("sf_out0", o[0], 32'(1));
    check("sf_out7", o[7], 32'(8));
    check("sf_out15", o[15], 32'(16));
    check("sf_ready_back", 32'(in_ready), 32'(1));
    step();
    check("sf_init_one_cycle", 32'(init), 32'(0));
    n = 1;
    while (frame_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("sf_done_after_init", 32'(n), 32'(CALC + 1));
    step();
    check("sf_done_one_cycle", 32'(frame_done), 32'(0));
    check("sf_busy_low", 32'(busy), 32'(0));
    wait_idle("sf_idle");

    // ---- Backpressure 101..132 ----
    for (int i = 101; i <= 116; i++) send(N'(i));
    check("bp_ready_low_116", 32'(in_ready), 32'(0));
    for (int i = 117; i <= 132; i++) send(N'(i));
    check("bp_ready_low_132", 32'(in_ready), 32'(0));
    check("bp_busy", 32'(busy), 32'(1));
    check("bp_hold0", o[0], 32'(101));
    check("bp_hold15", o[15], 32'(116));
    wait_done("bp_wait_done");
    check("bp_at_done_hold0", o[0], 32'(101));
    check("bp_at_done_ready", 32'(in_ready), 32'(0));
    step();
    check("bp_idle_hold0", o[0], 32'(101));
    check("bp_idle_ready", 32'(in_ready), 32'(0));
    check("bp_idle_busy", 32'(busy), 32'(0));
    step();
    check("bp_copy_init", 32'(init), 32'(1));
    check("bp_copy_out0", o[0], 32'(117));
    check("bp_copy_out15", o[15], 32'(132));
    check("bp_copy_ready", 32'(in_ready), 32'(1));
    wait_idle("bp_idle");

    // ---- Gapped input, 3 frames ----
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        repeat ($urandom_range(0, 3)) step();
        send(N'(500 + f * 16 + i));
      end
    end
    wait_idle("gap_idle");

    // ---- Mid-frame reset, with a sample offered on the reset edge ----
    for (int i = 0; i < 7; i++) send(N'(301 + i));
    exp_q.delete();
    in_valid = 1'b1;
    in_data  = N'(999);
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("mr_wr_ptr", 32'(dbg_wr_ptr), 32'(0));
    check("mr_ready", 32'(in_ready), 32'(1));
    check("mr_busy", 32'(busy), 32'(0));
    check("mr_out0_cleared", o[0], 32'(0));
    init_before = init_count;
    for (int i = 0; i < 16; i++) send(N'(311 + i));
    check("mr_no_early_init", 32'(init_count), 32'(init_before));
    wait_idle("mr_idle");

    // ---- Reset during RUN at cnt=10 ----
    for (int i = 0; i < 16; i++) send(N'(201 + i));
    step();
    check("rr_init", 32'(init), 32'(1));
    repeat (11) step();
    check("rr_in_run", 32'(dbg_state), 32'(2));
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_q.delete();
    check("rr_busy", 32'(busy), 32'(0));
    check("rr_init_low", 32'(init), 32'(0));
    check("rr_done_low", 32'(frame_done), 32'(0));
    check("rr_ready", 32'(in_ready), 32'(1));
    for (int k = 0; k < 16; k++) check($sformatf("rr_out%0d", k), o[k], 32'(0));
    done_before = done_count;
    repeat (60) step();
    check("rr_no_done", 32'(done_count), 32'(done_before));

    // ---- Stuck valid while full ----
    for (int i = 0; i < 16; i++) send(N'(401 + i));
    for (int i = 0; i < 16; i++) send(N'(417 + i));
    check("sv_busy", 32'(busy), 32'(1));
    check("sv_full", 32'(dbg_full), 32'(1));
    check("sv_wr_ptr", 32'(dbg_wr_ptr), 32'(0));
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = N'($urandom_range(1000, 60000));
      step();
      check("sv_wr_ptr_hold", 32'(dbg_wr_ptr), 32'(0));
      check("sv_ready_low", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    wait_idle("sv_idle");

    // ---- Totals ----
    check("total_inits", 32'(init_count), 32'(10));
    check("total_dones", 32'(done_count), 32'(9));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
